scroll_window_gen: RTL

SCROLL_WINDOW_GEN -- requirements
Module: scroll_window_gen

---
 rtl/scroll_window_gen.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/scroll_window_gen.sv
// Four-digit scrolling window over a message of up to 16 character codes.
// Optional macro SCROLL_PAUSE_EN adds a pause input that freezes scrolling.
module scroll_window_gen #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic        CLOCK_50,
  input  logic        KEY0,
  input  logic        clear,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_char,
  input  logic        wr_last,
`ifdef SCROLL_PAUSE_EN
  input  logic        pause,
`endif
  output logic [15:0] win_char,
  output logic [3:0]  win_blank,
  output logic        win_step
);

  // state   | meaning
  // S_EMPTY | no message stored, accepting the first character
  // S_LOAD  | message partly loaded, accepting further characters
  // S_RUN   | message complete, window scrolling, writes ignored
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  localparam int unsigned   TW        = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  state_t        state_q, state_d;
  logic [4:0]    len_q, len_d;
  logic [4:0]    p_q, p_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0]    msg_q [16];
  logic [3:0]    msg_d [16];
  logic          pend_q, pend_d;
  logic [15:0]   win_char_q, win_char_d;
  logic [3:0]    win_blank_q, win_blank_d;
  logic          win_step_q, win_step_d;

  logic [4:0]    stream_len;
  logic [15:0]   view_char;
  logic [3:0]    view_blank;
  logic          accept;
  logic          run_en;

`ifdef SCROLL_PAUSE_EN
  assign run_en = !pause;
`else
  assign run_en = 1'b1;
`endif

  assign wr_ready   = (state_q != S_RUN);
  assign accept     = wr_valid && wr_ready && !clear;
  assign stream_len = len_q + 5'd4;

  // Digit k shows stream position p+(3-k), wrapped once; L >= 5 so one wrap suffices.
  for (genvar k = 0; k < 4; k++) begin : g_digit
    localparam logic [4:0] OFS = 5'(3 - k);
    logic [4:0] raw;
    logic [4:0] idx;
    assign raw               = p_q + OFS;
    assign idx               = (raw >= stream_len) ? (raw - stream_len) : raw;
    assign view_blank[k]     = (idx >= len_q);
    assign view_char[4*k+:4] = view_blank[k] ? 4'h0 : msg_q[idx[3:0]];
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    p_d         = p_q;
    tick_d      = tick_q;
    msg_d       = msg_q;
    pend_d      = 1'b0;
    win_char_d  = win_char_q;
    win_blank_d = win_blank_q;
    win_step_d  = 1'b0;

    // A position change made last cycle becomes visible now.
    if (pend_q) begin
      win_char_d  = view_char;
      win_blank_d = view_blank;
      win_step_d  = 1'b1;
    end

    if (clear) begin
      state_d     = S_EMPTY;
      len_d       = 5'd0;
      p_d         = 5'd0;
      tick_d      = '0;
      pend_d      = 1'b0;
      win_char_d  = 16'h0000;
      win_blank_d = 4'hF;
      win_step_d  = (win_blank_q != 4'hF);
    end else begin
      unique case (state_q)
        S_EMPTY, S_LOAD: begin
          if (accept) begin
            msg_d[len_q[3:0]] = wr_char;
            len_d             = len_q + 5'd1;
            if (wr_last || (len_q == 5'd15)) begin
              state_d = S_RUN;
              p_d     = 5'd0;
              tick_d  = '0;
              pend_d  = 1'b1;
            end else begin
              state_d = S_LOAD;
            end
          end
        end
        S_RUN: begin
          if (run_en) begin
            if (tick_q == TICK_LAST) begin
              tick_d = '0;
              p_d    = (p_q == stream_len - 5'd1) ? 5'd0 : p_q + 5'd1;
              pend_d = 1'b1;
            end else begin
              tick_d = tick_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state_q     <= S_EMPTY;
      len_q       <= 5'd0;
      p_q         <= 5'd0;
      tick_q      <= '0;
      pend_q      <= 1'b0;
      win_char_q  <= 16'h0000;
      win_blank_q <= 4'hF;
      win_step_q  <= 1'b0;
      for (int i = 0; i < 16; i++) msg_q[i] <= 4'h0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      p_q         <= p_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      win_char_q  <= win_char_d;
      win_blank_q <= win_blank_d;
      win_step_q  <= win_step_d;
      for (int i = 0; i < 16; i++) msg_q[i] <= msg_d[i];
    end
  end

  assign win_char  = win_char_q;
  assign win_blank = win_blank_q;
  assign win_step  = win_step_q;

endmodule
